// File: rtl/matrix_loader3by3.sv
// matrix_loader3by3
// Collects a serial stream of 18 unsigned entries (matrix A row-major, then
// matrix B row-major) and presents them as six packed 3-entry vectors for a
// 3x3 matrix multiplier: the rows of A and the columns of B (B transposed).
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   abort      - synchronous discard of the current load (vectors kept)
//   in_valid   - in_entry carries a valid entry
//   in_ready   - loader accepts an entry this cycle
//   in_entry   - serial matrix entry, ENTRY_SIZE bits
//   out_valid  - a complete A/B pair is presented
//   out_ready  - downstream consumes the pair
//   matrixAv1..3 - rows 1..3 of A, element 1 in the top ENTRY_SIZE bits
//   matrixBv1..3 - columns 1..3 of B, element 1 in the top ENTRY_SIZE bits
module matrix_loader3by3 #(
    parameter int ENTRY_SIZE  = 5,
    parameter int VECTOR_SIZE = 3 * ENTRY_SIZE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   abort,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ENTRY_SIZE-1:0]  in_entry,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [VECTOR_SIZE-1:0] matrixAv1,
    output logic [VECTOR_SIZE-1:0] matrixAv2,
    output logic [VECTOR_SIZE-1:0] matrixAv3,
    output logic [VECTOR_SIZE-1:0] matrixBv1,
    output logic [VECTOR_SIZE-1:0] matrixBv2,
    output logic [VECTOR_SIZE-1:0] matrixBv3
);

    localparam logic [0:0] LOAD = 1'b0;
    localparam logic [0:0] FULL = 1'b1;
    localparam logic [4:0] LAST = 5'd17;

    logic [0:0]            state;
    logic [4:0]            cnt;
    // Storage in stream order: a_mem[3*(i-1)+(j-1)] holds Aij, same for B.
    logic [ENTRY_SIZE-1:0] a_mem [9];
    logic [ENTRY_SIZE-1:0] b_mem [9];
    logic                  accept;

    // in_ready is gated with rst_n so nothing looks acceptable during reset.
    assign in_ready  = rst_n & (state == LOAD);
    assign out_valid = (state == FULL);
    assign accept    = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
            cnt   <= '0;
        end else if (abort) begin
            // abort wins over any simultaneous accept or consume
            state <= LOAD;
            cnt   <= '0;
        end else if (accept) begin
            if (cnt == LAST) begin
                state <= FULL;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 5'd1;
            end
        end else if (state == FULL && out_ready) begin
            state <= LOAD;
        end
    end

    // Entries are only overwritten, never cleared between pairs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++) begin
                a_mem[k] <= '0;
                b_mem[k] <= '0;
            end
        end else if (!abort && accept) begin
            for (int k = 0; k < 9; k++) begin
                if (cnt == 5'(k))
                    a_mem[k] <= in_entry;
                if (cnt == 5'(k + 9))
                    b_mem[k] <= in_entry;
            end
        end
    end

    // Rows of A are contiguous in stream order.
    assign matrixAv1 = {a_mem[0], a_mem[1], a_mem[2]};
    assign matrixAv2 = {a_mem[3], a_mem[4], a_mem[5]};
    assign matrixAv3 = {a_mem[6], a_mem[7], a_mem[8]};

    // Columns of B gather every third entry (transpose).
    assign matrixBv1 = {b_mem[0], b_mem[3], b_mem[6]};
    assign matrixBv2 = {b_mem[1], b_mem[4], b_mem[7]};
    assign matrixBv3 = {b_mem[2], b_mem[5], b_mem[8]};

endmodule

// File: tb/tb_matrix_loader3by3.sv
// tb_matrix_loader3by3
// Randomized and directed stimulus for matrix_loader3by3, checked every cycle
// against a matrix-level model, plus literal expectations for the directed
// scenarios.
module tb_matrix_loader3by3;

    localparam int E = 5;
    localparam int V = 3 * E;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         abort;
    logic         in_valid;
    logic         in_ready;
    logic [E-1:0] in_entry;
    logic         out_valid;
    logic         out_ready;
    logic [V-1:0] matrixAv1, matrixAv2, matrixAv3;
    logic [V-1:0] matrixBv1, matrixBv2, matrixBv3;

    matrix_loader3by3 #(.ENTRY_SIZE(E), .VECTOR_SIZE(V)) dut (
        .clk(clk), .rst_n(rst_n), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_entry(in_entry),
        .out_valid(out_valid), .out_ready(out_ready),
        .matrixAv1(matrixAv1), .matrixAv2(matrixAv2), .matrixAv3(matrixAv3),
        .matrixBv1(matrixBv1), .matrixBv2(matrixBv2), .matrixBv3(matrixBv3)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  mA [3][3];
    int  mB [3][3];
    int  m_n;      // entries taken so far in the current load
    bit  m_full;

    function automatic logic [V-1:0] pack3(input int e1, input int e2, input int e3);
        return {E'(e1), E'(e2), E'(e3)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n = 0;
            m_full = 1'b0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    mA[i][j] = 0;
                    mB[i][j] = 0;
                end
        end else if (abort) begin
            m_n = 0;
            m_full = 1'b0;
        end else if (!m_full && in_valid) begin
            if (m_n < 9) mA[m_n / 3][m_n % 3] = int'(in_entry);
            else         mB[(m_n - 9) / 3][(m_n - 9) % 3] = int'(in_entry);
            m_n++;
            if (m_n == 18) begin
                m_n = 0;
                m_full = 1'b1;
            end
        end else if (m_full && out_ready) begin
            m_full = 1'b0;
        end
    end

    // One compare process, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("out_valid", 32'(out_valid), 32'(m_full));
            cmp("in_ready",  32'(in_ready),  32'(!m_full && rst_n === 1'b1));
            cmp("Av1", 32'(matrixAv1), 32'(pack3(mA[0][0], mA[0][1], mA[0][2])));
            cmp("Av2", 32'(matrixAv2), 32'(pack3(mA[1][0], mA[1][1], mA[1][2])));
            cmp("Av3", 32'(matrixAv3), 32'(pack3(mA[2][0], mA[2][1], mA[2][2])));
            cmp("Bv1", 32'(matrixBv1), 32'(pack3(mB[0][0], mB[1][0], mB[2][0])));
            cmp("Bv2", 32'(matrixBv2), 32'(pack3(mB[0][1], mB[1][1], mB[2][1])));
            cmp("Bv3", 32'(matrixBv3), 32'(pack3(mB[0][2], mB[1][2], mB[2][2])));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit_ref_vectors(input string tag);
        cmp({tag, "_Av1"}, 32'(matrixAv1), 32'h443);
        cmp({tag, "_Av2"}, 32'(matrixAv2), 32'h10A6);
        cmp({tag, "_Av3"}, 32'(matrixAv3), 32'h1D09);
        cmp({tag, "_Bv1"}, 32'(matrixBv1), 32'h487);
        cmp({tag, "_Bv2"}, 32'(matrixBv2), 32'h8A8);
        cmp({tag, "_Bv3"}, 32'(matrixBv3), 32'hCC9);
    endtask

    task automatic lit_all_vectors(input string tag, input logic [V-1:0] exp);
        cmp({tag, "_Av1"}, 32'(matrixAv1), 32'(exp));
        cmp({tag, "_Av2"}, 32'(matrixAv2), 32'(exp));
        cmp({tag, "_Av3"}, 32'(matrixAv3), 32'(exp));
        cmp({tag, "_Bv1"}, 32'(matrixBv1), 32'(exp));
        cmp({tag, "_Bv2"}, 32'(matrixBv2), 32'(exp));
        cmp({tag, "_Bv3"}, 32'(matrixBv3), 32'(exp));
    endtask

    function automatic logic [E-1:0] ref_stream(input int k);
        return E'((k % 9) + 1);
    endfunction

    initial begin
        int acc;
        int cyc;
        int rises [$];
        logic prev_ov;

        rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_entry = '0;
        #2;
        chk_en = 1'b1;
        step();
        // reset state
        cmp("rst_in_ready", 32'(in_ready), 32'd0);
        cmp("rst_out_valid", 32'(out_valid), 32'd0);
        lit_all_vectors("rst", '0);
        rst_n = 1'b1;
        step();
        cmp("rel_in_ready", 32'(in_ready), 32'd1);

        // reference load with in_valid held high
        in_valid = 1'b1;
        for (int k = 0; k < 18; k++) begin
            in_entry = ref_stream(k);
            step();
            if (k == 16) cmp("early_out_valid", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        cmp("ref_out_valid", 32'(out_valid), 32'd1);
        lit_ref_vectors("ref");

        // hold under backpressure
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'(k & 1);
            in_entry = E'($urandom);
            step();
            cmp("hold_out_valid", 32'(out_valid), 32'd1);
            cmp("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        lit_ref_vectors("hold");
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        cmp("consume_out_valid", 32'(out_valid), 32'd0);
        cmp("consume_in_ready", 32'(in_ready), 32'd1);

        // gapped load of the reference stream
        acc = 0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 400) begin
            in_valid = 1'($urandom);
            in_entry = in_valid ? ref_stream(acc) : E'($urandom);
            if (in_valid && in_ready) acc++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        cmp("gap_out_valid", 32'(out_valid), 32'd1);
        cmp("gap_accepts", 32'(acc), 32'd18);
        lit_ref_vectors("gap");
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // abort after 7 accepts, then a full load of 31s
        in_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_entry = E'($urandom_range(0, 30));
            step();
        end
        abort = 1'b1;
        in_entry = 5'd3;
        step();
        abort = 1'b0;
        in_entry = 5'd31;
        for (int k = 0; k < 18; k++) begin
            step();
            if (k == 10) cmp("abort_no_early_valid", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        cmp("abort_out_valid", 32'(out_valid), 32'd1);
        lit_all_vectors("ones", 15'h7FFF);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // async reset mid-cycle after 12 accepts
        in_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            in_entry = E'($urandom);
            step();
        end
        #3;
        rst_n = 1'b0;
        #1;
        cmp("arst_in_ready", 32'(in_ready), 32'd0);
        cmp("arst_out_valid", 32'(out_valid), 32'd0);
        lit_all_vectors("arst", '0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 18; k++) begin
            in_entry = E'($urandom);
            step();
            if (k == 16) cmp("arst_17_out_valid", 32'(out_valid), 32'd0);
        end
        cmp("arst_18_out_valid", 32'(out_valid), 32'd1);

        // back-to-back pairs with out_ready tied high
        out_ready = 1'b1;
        prev_ov = out_valid;
        for (int c = 0; c < 60; c++) begin
            in_entry = E'($urandom);
            step();
            if (out_valid && !prev_ov) rises.push_back(c);
            prev_ov = out_valid;
        end
        cmp("b2b_pairs", 32'(rises.size() >= 2), 32'd1);
        if (rises.size() >= 2)
            cmp("b2b_period", 32'(rises[1] - rises[0]), 32'd19);

        // random soak
        for (int c = 0; c < 600; c++) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            abort     = ($urandom_range(0, 39) == 0);
            in_entry  = E'($urandom);
            step();
        end
        abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        step();
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/matrix_loader3by3.md
MATRIX_LOADER3BY3 -- requirements
Module: matrix_loader3by3

Interface
REQ-001 The block SHALL have parameter ENTRY_SIZE, default 5, giving the width of one unsigned matrix entry.
REQ-002 The block SHALL have parameter VECTOR_SIZE, default 3*ENTRY_SIZE, giving the width of one packed 3-entry vector.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port abort, input, 1 bit: synchronous discard of the current load.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_entry carries a valid entry.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the loader accepts an entry this cycle.
REQ-008 The block SHALL have port in_entry, input, ENTRY_SIZE bits: serial matrix entry.
REQ-009 The block SHALL have port out_valid, output, 1 bit: a complete A/B pair is presented.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream multiplier consumes the pair.
REQ-011 The block SHALL have ports matrixAv1, matrixAv2, matrixAv3, outputs, VECTOR_SIZE bits each: rows 1-3 of A.
REQ-012 The block SHALL have ports matrixBv1, matrixBv2, matrixBv3, outputs, VECTOR_SIZE bits each: columns 1-3 of B (B transposed), in the form the 3x3 multiplier consumes.

Function
REQ-013 An entry SHALL be accepted on a rising edge exactly when in_valid=1 and in_ready=1.
REQ-014 The input stream SHALL be 18 entries: A row-major (A11,A12,A13,A21..A33), then B row-major (B11,B12,B13,B21..B33).
REQ-015 In every packed vector, element 1 SHALL occupy bits [VECTOR_SIZE-1:VECTOR_SIZE-ENTRY_SIZE], element 2 SHALL occupy the next ENTRY_SIZE bits down, and element 3 SHALL occupy [ENTRY_SIZE-1:0].
REQ-016 Aij SHALL be written to element j of matrixAv(i).
REQ-017 Bij SHALL be written to element i of matrixBv(j) (transpose).
REQ-018 The block SHALL implement a two-state FSM: LOAD and FULL, with a 5-bit entry counter cnt covering 0..17.
REQ-019 In LOAD, in_ready SHALL be 1, out_valid SHALL be 0, and each accepted entry SHALL be written to the slot selected by cnt, after which cnt increments.
REQ-020 Acceptance with cnt=17 SHALL set the next state to FULL and cnt to 0, so out_valid=1 in the cycle immediately after the 18th accept.
REQ-021 In FULL, in_ready SHALL be 0, out_valid SHALL be 1, and all six vectors SHALL hold stable.
REQ-022 In FULL, out_valid=1 with out_ready=1 SHALL return the FSM to LOAD on that edge; there is no same-cycle refill, giving a minimum of 19 cycles per pair.
REQ-023 out_valid, once asserted, SHALL NOT drop until consumed.
REQ-024 Entries SHALL NOT be cleared between pairs; each slot is overwritten on its next accept.
REQ-025 Vector outputs SHALL be driven directly from registers, with no combinational path from in_entry.
REQ-026 abort=1 SHALL force LOAD and cnt=0 on that edge in either state, leave vector contents unchanged, and ignore any simultaneous accept or consume.
REQ-027 in_valid gaps SHALL stall loading without losing cnt.
REQ-028 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-029 rst_n=0 SHALL immediately set: state LOAD, cnt 0, all six vectors 0, out_valid 0, in_ready 1 (while rst_n=1).
REQ-030 Reset asserted mid-load or in FULL SHALL discard all progress; after release, loading restarts at A11.
REQ-031 in_ready SHALL be 0 while rst_n=0.

Verification
REQ-032 Load A=B=[[1,2,3],[4,5,6],[7,8,9]] (stream 1..9,1..9) with in_valid held high -> out_valid=1 one cycle after the 18th accept; matrixAv1=0x443, matrixAv2={4,5,6}=0x10A6, matrixAv3={7,8,9}=0x1D09; matrixBv1={1,4,7}=0x487, matrixBv2={2,5,8}=0x8A8, matrixBv3={3,6,9}=0xCC9.
REQ-033 Hold out_ready=0 for 10 cycles after the REQ-032 load -> out_valid stays 1, in_ready stays 0, vectors unchanged; raise out_ready -> next cycle out_valid=0 and in_ready=1.
REQ-034 Randomly toggle in_valid (~50%) while loading the REQ-032 stream -> identical vectors to REQ-032; exactly 18 accepts counted.
REQ-035 Assert abort after 7 accepts, then load 18 entries of value 31 -> all vectors 0x7FFF; the aborted partial load does not cause an early out_valid.
REQ-036 Assert rst_n=0 asynchronously mid-cycle after 12 accepts -> outputs zero immediately; after release, 18 fresh accepts are required before out_valid.
REQ-037 Feed two back-to-back pairs with out_ready tied to 1 -> one-cycle FULL per pair, 19-cycle period, second pair's vectors correct.
